// File: rtl/gpio_input_port.sv
`default_nettype none
// ============================================================================
// Module      : gpio_input_port
// Description : Memory-mapped GPIO input responder. Synchronises 32 external
//               pins, optionally debounces them, latches sticky rise/fall
//               flags and raises a level interrupt from enabled flags.
//               Register window of 8 words at BASE_ADDR, RAM-shaped bus.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_input_port #(
    parameter logic [9:0] BASE_ADDR = 10'h3F8
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] PIN_IN,
    input  logic [9:0]  ADDRESS,
    input  logic [31:0] DATA_IN,
    input  logic        WRITE_ENABLE,
    output logic [31:0] DATA_OUT,
    output logic        SELECTED,
    output logic        IRQ
);

    // Register offsets inside the 8-word window
    localparam logic [2:0] c_OFF_IN       = 3'd0;
    localparam logic [2:0] c_OFF_RISE     = 3'd1;
    localparam logic [2:0] c_OFF_FALL     = 3'd2;
    localparam logic [2:0] c_OFF_IRQ_EN   = 3'd3;
    localparam logic [2:0] c_OFF_DEBOUNCE = 3'd4;

    // Arm counter terminal value: three cycles after reset release
    localparam logic [1:0] c_ARM_DONE = 2'd3;

    // Registered state
    logic [31:0] r_s1;
    logic [31:0] r_s2;
    logic [31:0] r_stable;
    logic [31:0] r_cand;
    logic [31:0] r_rise;
    logic [31:0] r_fall;
    logic [31:0] r_irq_en;
    logic [15:0] r_debounce;
    logic [15:0] r_prescale;
    logic [1:0]  r_arm;
    logic        r_irq;

    // Combinational helpers
    logic        w_sel;
    logic [2:0]  w_off;
    logic        w_wr;
    logic        w_wr_rise;
    logic        w_wr_fall;
    logic        w_wr_irq_en;
    logic        w_wr_debounce;
    logic        w_armed;
    logic        w_bypass;
    logic        w_tick;
    logic [31:0] w_agree;
    logic [31:0] w_new_stable;
    logic [31:0] w_rise_set;
    logic [31:0] w_fall_set;
    logic [31:0] w_rise_clr;
    logic [31:0] w_fall_clr;

    // Address decode: upper seven address bits select the window
    assign w_sel = (ADDRESS[9:3] == BASE_ADDR[9:3]);
    assign w_off = ADDRESS[2:0];
    assign w_wr  = WRITE_ENABLE & w_sel;

    assign w_wr_rise     = w_wr && (w_off == c_OFF_RISE);
    assign w_wr_fall     = w_wr && (w_off == c_OFF_FALL);
    assign w_wr_irq_en   = w_wr && (w_off == c_OFF_IRQ_EN);
    assign w_wr_debounce = w_wr && (w_off == c_OFF_DEBOUNCE);

    assign w_armed  = (r_arm == c_ARM_DONE);
    assign w_bypass = (r_debounce == 16'd0);
    // One tick every D+1 cycles when debouncing is enabled
    assign w_tick   = !w_bypass && (r_prescale == r_debounce);

    // Bits whose synchronised level matches the previous tick's candidate
    assign w_agree = ~(r_s2 ^ r_cand);

    // Next debounced level: follow s2 when unarmed or bypassed; otherwise
    // accept only bits that agreed on two consecutive ticks
    always_comb begin
        w_new_stable = r_stable;
        if (!w_armed || w_bypass) begin
            w_new_stable = r_s2;
        end else if (w_tick) begin
            w_new_stable = (r_s2 & w_agree) | (r_stable & ~w_agree);
        end
    end

    // Edge detection is suppressed until the arm counter completes so that
    // pins held high through reset do not report a rising edge
    assign w_rise_set = w_armed ? (w_new_stable & ~r_stable) : 32'd0;
    assign w_fall_set = w_armed ? (~w_new_stable & r_stable) : 32'd0;
    assign w_rise_clr = w_wr_rise ? DATA_IN : 32'd0;
    assign w_fall_clr = w_wr_fall ? DATA_IN : 32'd0;

    // Two-flop synchroniser with no logic between the stages
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_s1 <= 32'd0;
            r_s2 <= 32'd0;
        end else begin
            r_s1 <= PIN_IN;
            r_s2 <= r_s1;
        end
    end

    // Arm counter: runs for the first three cycles after reset release
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_arm <= 2'd0;
        end else if (r_arm != c_ARM_DONE) begin
            r_arm <= r_arm + 2'd1;
        end
    end

    // Debounce prescaler, candidate and accepted level
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_prescale <= 16'd0;
            r_cand     <= 32'd0;
            r_stable   <= 32'd0;
        end else begin
            r_stable <= w_new_stable;
            if (w_wr_debounce) begin
                // Restart the debounce phase from the currently accepted level
                r_prescale <= 16'd0;
                r_cand     <= r_stable;
            end else begin
                if (w_bypass || w_tick) begin
                    r_prescale <= 16'd0;
                end else begin
                    r_prescale <= r_prescale + 16'd1;
                end
                if (w_tick) begin
                    r_cand <= r_s2;
                end
            end
        end
    end

    // Sticky edge flags: a new edge wins over a simultaneous W1C clear
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_rise <= 32'd0;
            r_fall <= 32'd0;
        end else begin
            r_rise <= (r_rise & ~w_rise_clr) | w_rise_set;
            r_fall <= (r_fall & ~w_fall_clr) | w_fall_set;
        end
    end

    // Software-writable configuration registers
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_irq_en   <= 32'd0;
            r_debounce <= 16'd0;
        end else begin
            if (w_wr_irq_en) begin
                r_irq_en <= DATA_IN;
            end
            if (w_wr_debounce) begin
                r_debounce <= DATA_IN[15:0];
            end
        end
    end

    // Level interrupt, registered from the flag and mask state
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |((r_rise | r_fall) & r_irq_en);
        end
    end

    // Read mux: zero when not selected or for unused offsets
    always_comb begin
        DATA_OUT = 32'd0;
        if (w_sel) begin
            case (w_off)
                c_OFF_IN:       DATA_OUT = r_stable;
                c_OFF_RISE:     DATA_OUT = r_rise;
                c_OFF_FALL:     DATA_OUT = r_fall;
                c_OFF_IRQ_EN:   DATA_OUT = r_irq_en;
                c_OFF_DEBOUNCE: DATA_OUT = {16'd0, r_debounce};
                default:        DATA_OUT = 32'd0;
            endcase
        end
    end

    assign SELECTED = w_sel;
    assign IRQ      = r_irq;

endmodule
`default_nettype wire

// File: doc/gpio_input_port.md
# gpio_input_port

Memory-mapped GPIO input responder sitting on the CPU data bus beside the data RAM; the input-side counterpart of the CPU's GPIO output. It synchronises 32 external pins, optionally debounces them, and latches sticky rising/falling-edge flags. It exposes them through an 8-word register window with the same ADDRESS / DATA_IN / WRITE_ENABLE / DATA_OUT shape as the RAM. A level interrupt is raised from enabled flags.

## Interface
- BASE_ADDR, 10'h3F8, word address of register window; must be 8-word aligned; decode is ADDRESS[9:3] == BASE_ADDR[9:3]
- CLK  in  1  rising-edge clock, shared with CPU and RAM
- RESET_N  in  1  synchronous active-low reset, sampled on CLK rising edge
- PIN_IN  in  32  asynchronous external input pins
- ADDRESS  in  10  word address from CPU (RAM_ADDR)
- DATA_IN  in  32  write data from CPU (RAM_WRITE_DATA)
- WRITE_ENABLE  in  1  write strobe from CPU (RAM_WRITE_ENABLE)
- DATA_OUT  out  32  read data; combinational from registered state
- SELECTED  out  1  combinational address-decode hit; top level uses it to mux DATA_OUT against RAM
- IRQ  out  1  registered interrupt, |((RISE|FALL) & IRQ_EN)

## Operation
- Registers at word offset ADDRESS[2:0]:
  - 0 IN: debounced pin level; read-only.
  - 1 RISE: sticky rising-edge flags; write-1-to-clear.
  - 2 FALL: sticky falling-edge flags; write-1-to-clear.
  - 3 IRQ_EN: read/write mask.
  - 4 DEBOUNCE: read/write; bits [15:0] = D, upper bits read 0.
  - 5-7: read 0, writes ignored.
- Not selected: DATA_OUT = 0; writes ignored.
- Sync: two-flop chain PIN_IN -> s1 -> s2, no logic between the flops.
- D = 0 (bypass): stable <= s2 every cycle.
- D > 0:
  - Prescaler counts 0..D and wraps; tick when prescaler == D, i.e. one tick every D+1 cycles.
  - On tick: cand <= s2; per bit, stable <= s2 if s2 == cand, otherwise stable holds.
  - A level must therefore match on two consecutive ticks to be accepted.
- Writing DEBOUNCE clears the prescaler to 0 and loads cand <= stable.
- Edge flags are set in the same cycle stable changes:
  - RISE[i] |= new_stable[i] & ~stable[i]
  - FALL[i] |= ~new_stable[i] & stable[i]
- W1C write to RISE/FALL clears bits where DATA_IN = 1. If set and clear hit the same bit in the same cycle, set wins.
- Reset arming: a 2-bit arm counter runs for the first 3 cycles after RESET_N deasserts.
  - While unarmed, stable <= s2 every cycle, ignoring D, and no flags are set.
  - Pins held high across reset therefore produce no RISE.

## Timing
- Reset values: s1, s2, stable, cand, RISE, FALL, IRQ_EN, DEBOUNCE, prescaler, arm = 0; IRQ = 0. DATA_OUT = 0 unless a selected read of a nonzero register.
- Reset mid-operation clears all state on the next edge, including pending flags and the debounce state.
- Latency with D = 0 and armed: PIN_IN change setup to edge k; IN/RISE/FALL visible after edge k+2; IRQ after edge k+3.
- Latency with D > 0: acceptance after the second agreeing tick, plus the 2-cycle sync.
- Glitch rejection: a pulse shorter than D+1 cycles, spanning at most one tick, is never accepted.
- Read: zero wait; DATA_OUT reflects register state as of the last edge, same-cycle as ADDRESS.
- Write: takes effect at the CLK edge where WRITE_ENABLE = 1 and SELECTED = 1.
- IRQ clears one cycle after the W1C edge that clears the last enabled flag, or after the edge that clears IRQ_EN.

## Test plan
- Reset with PIN_IN = 32'hFFFF_0000 held, release, wait 5 cycles.
  - Required: IN = FFFF0000, RISE = 0, FALL = 0, IRQ = 0.
- D = 0, IRQ_EN = 1; PIN_IN[0] 0 -> 1 before edge k.
  - Required: RISE = 1 readable after edge k+2; IRQ = 1 after k+3.
  - Write RISE <- 1: RISE = 0 and IRQ = 0 one cycle later.
- D = 4; 3-cycle high pulse on PIN_IN[5].
  - Required: IN[5] stays 0 and RISE[5] stays 0.
  - Then a 12-cycle high level: IN[5] = 1 and RISE[5] = 1; 12-cycle low: FALL[5] = 1.
- Falling edge on bit 2 in the same cycle as a W1C write FALL <- 32'h4.
  - Required: FALL[2] = 1 afterwards (set wins).
- Address decode:
  - Write 32'hDEAD at BASE+3: readback 0000DEAD.
  - Write at BASE+0 and BASE+6: no effect, BASE+6 reads 0.
  - Access at BASE-1: SELECTED = 0, DATA_OUT = 0.
- Assert RESET_N low for one cycle with RISE = FFFFFFFF and D = 100.
  - Required: all registers read 0 and IRQ = 0 on the next cycle.
